armleo_axi_bram_arbiter: RTL and testbench

// - 2:1 AXI4 arbiter that shares one AXI BRAM slave port (armleo_axi_bram) between two masters, e.g. I-fetch and D-port.
// - One transaction in flight at a time (the slave is single-transaction); round-robin grant.
// - Forwards the granted master's channels combinationally; the grant and FSM are registered.
//

---
 rtl/armleo_axi_bram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_armleo_axi_bram_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleo_axi_bram_arbiter.sv
// 2:1 AXI4 arbiter sharing one single-transaction BRAM slave between two masters.
// Define ARMLEO_AXI_ARB_FIXED_PRIORITY_EN for fixed priority (master 0 wins ties); default is round-robin.
module armleo_axi_bram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      m0_awvalid,
    input  logic [ADDR_WIDTH-1:0]     m0_awaddr,
    input  logic [7:0]                m0_awlen,
    input  logic [2:0]                m0_awsize,
    input  logic [1:0]                m0_awburst,
    input  logic [ID_WIDTH-1:0]       m0_awid,
    output logic                      m0_awready,
    input  logic                      m0_wvalid,
    input  logic [DATA_WIDTH-1:0]     m0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m0_wstrb,
    input  logic                      m0_wlast,
    output logic                      m0_wready,
    output logic                      m0_bvalid,
    output logic [1:0]                m0_bresp,
    output logic [ID_WIDTH-1:0]       m0_bid,
    input  logic                      m0_bready,
    input  logic                      m0_arvalid,
    input  logic [ADDR_WIDTH-1:0]     m0_araddr,
    input  logic [7:0]                m0_arlen,
    input  logic [2:0]                m0_arsize,
    input  logic [1:0]                m0_arburst,
    input  logic [ID_WIDTH-1:0]       m0_arid,
    output logic                      m0_arready,
    output logic                      m0_rvalid,
    output logic [DATA_WIDTH-1:0]     m0_rdata,
    output logic [1:0]                m0_rresp,
    output logic                      m0_rlast,
    output logic [ID_WIDTH-1:0]       m0_rid,
    input  logic                      m0_rready,

    input  logic                      m1_awvalid,
    input  logic [ADDR_WIDTH-1:0]     m1_awaddr,
    input  logic [7:0]                m1_awlen,
    input  logic [2:0]                m1_awsize,
    input  logic [1:0]                m1_awburst,
    input  logic [ID_WIDTH-1:0]       m1_awid,
    output logic                      m1_awready,
    input  logic                      m1_wvalid,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
    input  logic                      m1_wlast,
    output logic                      m1_wready,
    output logic                      m1_bvalid,
    output logic [1:0]                m1_bresp,
    output logic [ID_WIDTH-1:0]       m1_bid,
    input  logic                      m1_bready,
    input  logic                      m1_arvalid,
    input  logic [ADDR_WIDTH-1:0]     m1_araddr,
    input  logic [7:0]                m1_arlen,
    input  logic [2:0]                m1_arsize,
    input  logic [1:0]                m1_arburst,
    input  logic [ID_WIDTH-1:0]       m1_arid,
    output logic                      m1_arready,
    output logic                      m1_rvalid,
    output logic [DATA_WIDTH-1:0]     m1_rdata,
    output logic [1:0]                m1_rresp,
    output logic                      m1_rlast,
    output logic [ID_WIDTH-1:0]       m1_rid,
    input  logic                      m1_rready,

    output logic                      s_awvalid,
    output logic [ADDR_WIDTH-1:0]     s_awaddr,
    output logic [7:0]                s_awlen,
    output logic [2:0]                s_awsize,
    output logic [1:0]                s_awburst,
    output logic [ID_WIDTH-1:0]       s_awid,
    input  logic                      s_awready,
    output logic                      s_wvalid,
    output logic [DATA_WIDTH-1:0]     s_wdata,
    output logic [DATA_WIDTH/8-1:0]   s_wstrb,
    output logic                      s_wlast,
    input  logic                      s_wready,
    input  logic                      s_bvalid,
    input  logic [1:0]                s_bresp,
    input  logic [ID_WIDTH-1:0]       s_bid,
    output logic                      s_bready,
    output logic                      s_arvalid,
    output logic [ADDR_WIDTH-1:0]     s_araddr,
    output logic [7:0]                s_arlen,
    output logic [2:0]                s_arsize,
    output logic [1:0]                s_arburst,
    output logic [ID_WIDTH-1:0]       s_arid,
    input  logic                      s_arready,
    input  logic                      s_rvalid,
    input  logic [DATA_WIDTH-1:0]     s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rlast,
    input  logic [ID_WIDTH-1:0]       s_rid,
    output logic                      s_rready
);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

    state_t state;
    logic   gnt;
    logic   last_gnt;
    logic   req0, req1, winner, winner_aw;

    always_comb begin
        req0 = m0_awvalid | m0_arvalid;
        req1 = m1_awvalid | m1_arvalid;
`ifdef ARMLEO_AXI_ARB_FIXED_PRIORITY_EN
        winner = !req0;
`else
        winner = (req0 && req1) ? !last_gnt : req1;
`endif
        winner_aw = winner ? m1_awvalid : m0_awvalid;
    end

    // Channel forwarding: payloads follow gnt, valids/readys are gated by state and grant
    assign s_awvalid = (state == AW) && (gnt ? m1_awvalid : m0_awvalid);
    assign s_awaddr  = gnt ? m1_awaddr  : m0_awaddr;
    assign s_awlen   = gnt ? m1_awlen   : m0_awlen;
    assign s_awsize  = gnt ? m1_awsize  : m0_awsize;
    assign s_awburst = gnt ? m1_awburst : m0_awburst;
    assign s_awid    = gnt ? m1_awid    : m0_awid;
    assign m0_awready = (state == AW) && !gnt && s_awready;
    assign m1_awready = (state == AW) &&  gnt && s_awready;

    assign s_wvalid = (state == W) && (gnt ? m1_wvalid : m0_wvalid);
    assign s_wdata  = gnt ? m1_wdata : m0_wdata;
    assign s_wstrb  = gnt ? m1_wstrb : m0_wstrb;
    assign s_wlast  = gnt ? m1_wlast : m0_wlast;
    assign m0_wready = (state == W) && !gnt && s_wready;
    assign m1_wready = (state == W) &&  gnt && s_wready;

    assign s_bready  = (state == B) && (gnt ? m1_bready : m0_bready);
    assign m0_bvalid = (state == B) && !gnt && s_bvalid;
    assign m1_bvalid = (state == B) &&  gnt && s_bvalid;
    assign m0_bresp  = s_bresp;
    assign m1_bresp  = s_bresp;
    assign m0_bid    = s_bid;
    assign m1_bid    = s_bid;

    assign s_arvalid = (state == AR) && (gnt ? m1_arvalid : m0_arvalid);
    assign s_araddr  = gnt ? m1_araddr  : m0_araddr;
    assign s_arlen   = gnt ? m1_arlen   : m0_arlen;
    assign s_arsize  = gnt ? m1_arsize  : m0_arsize;
    assign s_arburst = gnt ? m1_arburst : m0_arburst;
    assign s_arid    = gnt ? m1_arid    : m0_arid;
    assign m0_arready = (state == AR) && !gnt && s_arready;
    assign m1_arready = (state == AR) &&  gnt && s_arready;

    assign s_rready  = (state == R) && (gnt ? m1_rready : m0_rready);
    assign m0_rvalid = (state == R) && !gnt && s_rvalid;
    assign m1_rvalid = (state == R) &&  gnt && s_rvalid;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;
    assign m0_rid    = s_rid;
    assign m1_rid    = s_rid;

    // Grant is held for the whole transaction; writes win over reads of the same master
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    gnt      <= winner;
                    last_gnt <= winner;
                    state    <= winner_aw ? AW : AR;
                end
                AW: if (s_awvalid && s_awready) state <= W;
                W:  if (s_wvalid && s_wready && s_wlast) state <= B;
                B:  if (s_bvalid && s_bready) state <= IDLE;
                AR: if (s_arvalid && s_arready) state <= R;
                R:  if (s_rvalid && s_rready && s_rlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_armleo_axi_bram_arbiter.sv
// Testbench for armleo_axi_bram_arbiter: two scripted masters, a behavioural BRAM slave and a read scoreboard.
module tb_armleo_axi_bram_arbiter;

    localparam int TMO = 200;

    logic clk;
    logic rst;

    logic [1:0]       m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
    logic [1:0][31:0] m_awaddr, m_araddr, m_wdata;
    logic [1:0][7:0]  m_awlen, m_arlen;
    logic [1:0][2:0]  m_awsize, m_arsize;
    logic [1:0][1:0]  m_awburst, m_arburst;
    logic [1:0][3:0]  m_awid, m_arid, m_wstrb;
    wire  [1:0]       m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast;
    wire  [1:0][1:0]  m_bresp, m_rresp;
    wire  [1:0][3:0]  m_bid, m_rid;
    wire  [1:0][31:0] m_rdata;

    wire        s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
    wire [31:0] s_awaddr, s_araddr, s_wdata;
    wire [7:0]  s_awlen, s_arlen;
    wire [2:0]  s_awsize, s_arsize;
    wire [1:0]  s_awburst, s_arburst;
    wire [3:0]  s_awid, s_arid, s_wstrb;
    logic       s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
    logic [1:0] s_bresp, s_rresp;
    logic [3:0] s_bid, s_rid;
    logic [31:0] s_rdata;

    armleo_axi_bram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_awvalid(m_awvalid[0]), .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]),
        .m0_awburst(m_awburst[0]), .m0_awid(m_awid[0]), .m0_awready(m_awready[0]),
        .m0_wvalid(m_wvalid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]), .m0_wready(m_wready[0]),
        .m0_bvalid(m_bvalid[0]), .m0_bresp(m_bresp[0]), .m0_bid(m_bid[0]), .m0_bready(m_bready[0]),
        .m0_arvalid(m_arvalid[0]), .m0_araddr(m_araddr[0]), .m0_arlen(m_arlen[0]), .m0_arsize(m_arsize[0]),
        .m0_arburst(m_arburst[0]), .m0_arid(m_arid[0]), .m0_arready(m_arready[0]),
        .m0_rvalid(m_rvalid[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rlast(m_rlast[0]),
        .m0_rid(m_rid[0]), .m0_rready(m_rready[0]),
        .m1_awvalid(m_awvalid[1]), .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]),
        .m1_awburst(m_awburst[1]), .m1_awid(m_awid[1]), .m1_awready(m_awready[1]),
        .m1_wvalid(m_wvalid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]), .m1_wready(m_wready[1]),
        .m1_bvalid(m_bvalid[1]), .m1_bresp(m_bresp[1]), .m1_bid(m_bid[1]), .m1_bready(m_bready[1]),
        .m1_arvalid(m_arvalid[1]), .m1_araddr(m_araddr[1]), .m1_arlen(m_arlen[1]), .m1_arsize(m_arsize[1]),
        .m1_arburst(m_arburst[1]), .m1_arid(m_arid[1]), .m1_arready(m_arready[1]),
        .m1_rvalid(m_rvalid[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rlast(m_rlast[1]),
        .m1_rid(m_rid[1]), .m1_rready(m_rready[1]),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awid(s_awid), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arid(s_arid), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rready(s_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int timeouts = 0;
    int viol = 0;
    int m1_act = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] ref_mem [0:63];
    logic [31:0] ev_log;

    // Behavioural single-transaction BRAM slave; memory is reloaded on every reset
    logic [31:0] smem [0:63];
    logic [31:0] s_waddr_q, s_raddr_q, last_awaddr, last_wdata;
    logic [3:0]  s_wid_q, last_wstrb;
    logic [7:0]  s_rcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_awready <= 1'b1; s_wready <= 1'b0; s_bvalid <= 1'b0; s_bresp <= 2'b00; s_bid <= 4'h0;
            s_arready <= 1'b1; s_rvalid <= 1'b0; s_rlast <= 1'b0; s_rresp <= 2'b00; s_rid <= 4'h0;
            s_rdata <= 32'h0; s_rcnt <= 8'h0; s_waddr_q <= 32'h0; s_raddr_q <= 32'h0; s_wid_q <= 4'h0;
            last_awaddr <= 32'h0; last_wdata <= 32'h0; last_wstrb <= 4'h0;
            for (int i = 0; i < 64; i++) smem[i] <= 32'h1000_0000 + i;
        end else begin
            if (s_awvalid && s_awready) begin
                s_waddr_q <= s_awaddr; s_wid_q <= s_awid; last_awaddr <= s_awaddr;
                s_awready <= 1'b0; s_wready <= 1'b1;
            end
            if (s_wvalid && s_wready) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) smem[s_waddr_q[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                s_waddr_q <= s_waddr_q + 32'd4; last_wdata <= s_wdata; last_wstrb <= s_wstrb;
                if (s_wlast) begin
                    s_wready <= 1'b0; s_bvalid <= 1'b1; s_bid <= s_wid_q; s_bresp <= 2'b00;
                end
            end
            if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0; s_awready <= 1'b1;
            end
            if (s_arvalid && s_arready) begin
                s_arready <= 1'b0; s_rvalid <= 1'b1; s_rdata <= smem[s_araddr[7:2]]; s_rid <= s_arid;
                s_rlast <= (s_arlen == 8'd0); s_rcnt <= s_arlen; s_raddr_q <= s_araddr + 32'd4;
            end
            if (s_rvalid && s_rready) begin
                if (s_rlast) begin
                    s_rvalid <= 1'b0; s_rlast <= 1'b0; s_arready <= 1'b1;
                end else begin
                    s_rdata <= smem[s_raddr_q[7:2]]; s_raddr_q <= s_raddr_q + 32'd4;
                    s_rcnt <= s_rcnt - 8'd1; s_rlast <= (s_rcnt == 8'd1);
                end
            end
        end
    end

    // Handshake log (AW0=1 AW1=2 AR0=3 AR1=4 B0=5 B1=6, newest in low nibble) and exclusivity monitor
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (m_awvalid[i] && m_awready[i]) ev_log = (ev_log << 4) | (32'd1 + 32'(i));
                if (m_arvalid[i] && m_arready[i]) ev_log = (ev_log << 4) | (32'd3 + 32'(i));
                if (m_bvalid[i] && m_bready[i])   ev_log = (ev_log << 4) | (32'd5 + 32'(i));
            end
            if (m_rvalid == 2'b11) viol++;
            if ((m_awready[0] | m_wready[0] | m_bvalid[0] | m_arready[0] | m_rvalid[0]) &&
                (m_awready[1] | m_wready[1] | m_bvalid[1] | m_arready[1] | m_rvalid[1])) viol++;
            if (m_awready[1] | m_wready[1] | m_bvalid[1] | m_arready[1] | m_rvalid[1]) m1_act++;
        end
    end

    function automatic logic sig(input int k, input int m);
        case (k)
            0: return m_awready[m];
            1: return m_wready[m];
            2: return m_bvalid[m];
            default: return m_arready[m];
        endcase
    endfunction

    function automatic logic [14:0] ctl_vec();
        return {m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready};
    endfunction

    task automatic init_ref();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + i;
    endtask

    task automatic clear_inputs();
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
        m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_awlen = '0; m_arlen = '0; m_awsize = '0;
        m_arsize = '0; m_awburst = '0; m_arburst = '0; m_awid = '0; m_arid = '0; m_wstrb = '0;
    endtask

    // Waits from a negedge until the selected ready/valid is seen; leaves time at negedge+1
    task automatic wait_hs(input int k, input int m);
        int c = 0;
        #1;
        while (!sig(k, m) && c < TMO) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (c >= TMO) begin
            timeouts++;
            $display("[TB] FAIL handshake_timeout kind=%0d m%0d got=0 exp=1", k, m);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        init_ref();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ev_log = 32'h0;
    endtask

    // Master write of one beat; entered and left at a negedge
    task automatic m_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] id);
        for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
        m_awvalid[m] = 1'b1; m_awaddr[m] = addr; m_awlen[m] = 8'd0; m_awsize[m] = 3'd2;
        m_awburst[m] = 2'd1; m_awid[m] = id;
        wait_hs(0, m);
        @(negedge clk);
        m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b1; m_wdata[m] = data; m_wstrb[m] = strb; m_wlast[m] = 1'b1;
        wait_hs(1, m);
        @(negedge clk);
        m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0; m_bready[m] = 1'b1;
        wait_hs(2, m);
        checks++;
        if ({m_bresp[m], m_bid[m]} !== {2'b00, id}) begin
            errors++;
            $display("[TB] FAIL bresp_bid m%0d got=%h/%h exp=0/%h", m, m_bresp[m], m_bid[m], id);
        end
        @(negedge clk);
        m_bready[m] = 1'b0;
    endtask

    // Master INCR read; expected beats are pushed at the AR handshake and popped per R beat
    task automatic m_read(input int m, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, input bit toggle);
        exp_t e;
        int   got = 0;
        int   c = 0;
        bit   rr = 1'b1;
        bit   done = 1'b0;
        m_arvalid[m] = 1'b1; m_araddr[m] = addr; m_arlen[m] = len; m_arsize[m] = 3'd2;
        m_arburst[m] = 2'd1; m_arid[m] = id;
        wait_hs(3, m);
        for (int i = 0; i <= int'(len); i++) begin
            e.data = ref_mem[6'(int'(addr[7:2]) + i)];
            e.id   = id;
            e.last = (i == int'(len));
            if (m == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(negedge clk);
        m_arvalid[m] = 1'b0;
        while (!done && c < TMO) begin
            m_rready[m] = rr;
            #1;
            if (m_rvalid[m] && rr) begin
                if (m == 0 && q0.size() > 0) e = q0.pop_front();
                else if (m == 1 && q1.size() > 0) e = q1.pop_front();
                else e = '0;
                checks++;
                if ({m_rdata[m], m_rid[m], m_rlast[m], m_rresp[m]} !== {e.data, e.id, e.last, 2'b00}) begin
                    errors++;
                    $display("[TB] FAIL rbeat m%0d beat%0d got=%h/%h/%b/%h exp=%h/%h/%b/0", m, got,
                             m_rdata[m], m_rid[m], m_rlast[m], m_rresp[m], e.data, e.id, e.last);
                end
                got++;
                done = m_rlast[m] || (got > int'(len));
            end
            @(negedge clk);
            if (toggle) rr = !rr;
            c++;
        end
        if (!done) begin
            timeouts++;
            $display("[TB] FAIL read_timeout m%0d got=%0d beats exp=%0d", m, got, int'(len) + 1);
        end
        m_rready[m] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        init_ref();
        ev_log = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (ctl_vec() !== 15'h0) begin
            errors++;
            $display("[TB] FAIL reset_ctl got=%h exp=0", ctl_vec());
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ctl_vec() !== 15'h0) begin
            errors++;
            $display("[TB] FAIL idle_ctl got=%h exp=0", ctl_vec());
        end
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int t0 = timeouts;
        int a0 = m1_act;
        ev_log = 32'h0;
        m_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 4'h5);
        checks++;
        if ({last_awaddr, last_wdata, last_wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin
            errors++;
            $display("[TB] FAIL slave_write got=%h/%h/%h exp=10/deadbeef/f", last_awaddr, last_wdata, last_wstrb);
        end
        checks++;
        if (ev_log !== 32'h15) begin
            errors++;
            $display("[TB] FAIL write_order got=%h exp=15", ev_log);
        end
        checks++;
        if (m1_act !== a0) begin
            errors++;
            $display("[TB] FAIL m1_quiet got=%0d active cycles exp=0", m1_act - a0);
        end
        checks++;
        if (timeouts !== t0) begin
            errors++;
            $display("[TB] FAIL write_timeouts got=%0d exp=0", timeouts - t0);
        end
    endtask

    task automatic test_simultaneous_read();
        int t0, v0;
        do_reset();
        t0 = timeouts;
        v0 = viol;
        fork
            m_read(0, 32'h0, 8'd0, 4'h1, 1'b0);
            m_read(1, 32'h4, 8'd0, 4'h2, 1'b0);
        join
        checks++;
        if (ev_log !== 32'h34) begin
            errors++;
            $display("[TB] FAIL sim_read_order got=%h exp=34", ev_log);
        end
        checks++;
        if (viol !== v0 || timeouts !== t0) begin
            errors++;
            $display("[TB] FAIL sim_read_excl got=%0d/%0d exp=0/0", viol - v0, timeouts - t0);
        end
    endtask

    task automatic test_write_priority();
        int t0 = timeouts;
        ev_log = 32'h0;
        fork
            m_write(0, 32'h20, 32'hCAFEBABE, 4'b0101, 4'h6);
            m_read(0, 32'h20, 8'd0, 4'h3, 1'b0);
        join
        checks++;
        if (ev_log !== 32'h153) begin
            errors++;
            $display("[TB] FAIL write_before_read got=%h exp=153", ev_log);
        end
        checks++;
        if (timeouts !== t0) begin
            errors++;
            $display("[TB] FAIL wr_prio_timeouts got=%0d exp=0", timeouts - t0);
        end
    endtask

    task automatic test_burst_read();
        int t0 = timeouts;
        m_read(1, 32'h40, 8'd3, 4'h7, 1'b1);
        m_rready[1] = 1'b1;
        #1;
        checks++;
        if ({s_rready, m_rvalid[1]} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL burst_release got=%b exp=00", {s_rready, m_rvalid[1]});
        end
        m_rready[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (timeouts !== t0) begin
            errors++;
            $display("[TB] FAIL burst_timeouts got=%0d exp=0", timeouts - t0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_order;
        int t0;
        do_reset();
        t0 = timeouts;
`ifdef ARMLEO_AXI_ARB_FIXED_PRIORITY_EN
        exp_order = 32'h333444;
`else
        exp_order = 32'h343434;
`endif
        fork
            begin
                for (int k = 0; k < 3; k++) m_read(0, 32'(k * 4), 8'd0, 4'(k), 1'b0);
            end
            begin
                for (int k = 0; k < 3; k++) m_read(1, 32'(32 + k * 4), 8'd0, 4'(8 + k), 1'b0);
            end
        join
        checks++;
        if (ev_log !== exp_order) begin
            errors++;
            $display("[TB] FAIL grant_order got=%h exp=%h", ev_log, exp_order);
        end
        checks++;
        if (timeouts !== t0) begin
            errors++;
            $display("[TB] FAIL b2b_timeouts got=%0d exp=0", timeouts - t0);
        end
    endtask

    task automatic test_reset_mid();
        int t0 = timeouts;
        m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h30; m_awlen[0] = 8'd0; m_awsize[0] = 3'd2;
        m_awburst[0] = 2'd1; m_awid[0] = 4'h4;
        wait_hs(0, 0);
        @(negedge clk);
        m_awvalid[0] = 1'b0;
        #1;
        checks++;
        if (m_wready[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL in_w_state got=%b exp=1", m_wready[0]);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ctl_vec() !== 15'h0) begin
            errors++;
            $display("[TB] FAIL midreset_ctl got=%h exp=0", ctl_vec());
        end
        clear_inputs();
        init_ref();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ev_log = 32'h0;
        m_read(1, 32'h8, 8'd0, 4'h9, 1'b0);
        checks++;
        if (ev_log !== 32'h4 || timeouts !== t0) begin
            errors++;
            $display("[TB] FAIL post_reset_read got=%h/%0d exp=4/0", ev_log, timeouts - t0);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_simultaneous_read();
        test_write_priority();
        test_burst_read();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("[TB] FAIL exclusivity got=%0d violations exp=0", viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout got=running exp=finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
